// File: rtl/cms_topk_table.sv
// Top-K tracker: keeps the DEPTH keys with the largest values; supports a streamed drain (optional CMS_TOPK_CLEAR_ON_DRAIN_EN).
// Latency: accept -> kv_in_ready again in 2 cycles (no change) or DEPTH+2 (table changed, min rescan).
// Backpressure: kv_in_ready low outside IDLE or while drain_req is high; drain beats hold until kv_out_ready.
module cms_topk_table #(
    parameter int DEPTH       = 16,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int IDX_W       = $clog2(DEPTH)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [KEY_WIDTH-1:0]   kv_in_key,
    input  logic [VALUE_WIDTH-1:0] kv_in_value,
    input  logic                   kv_in_valid,
    output logic                   kv_in_ready,
    input  logic                   drain_req,
    output logic [KEY_WIDTH-1:0]   kv_out_key,
    output logic [VALUE_WIDTH-1:0] kv_out_value,
    output logic                   kv_out_valid,
    input  logic                   kv_out_ready,
    output logic                   kv_out_last,
    output logic                   drain_done,
    output logic [IDX_W:0]         occupancy,
    output logic [VALUE_WIDTH-1:0] min_value,
    output logic [31:0]            dropped_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_SCAN, S_DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [KEY_WIDTH-1:0]   r_key [DEPTH];
    logic [VALUE_WIDTH-1:0] r_val [DEPTH];
    logic [DEPTH-1:0]       r_vld;
    logic [KEY_WIDTH-1:0]   r_cand_key;
    logic [VALUE_WIDTH-1:0] r_cand_val;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W:0]         r_occ;
    logic [VALUE_WIDTH-1:0] r_min_value;
    logic [IDX_W-1:0]       r_min_idx;
    logic [31:0]            r_dropped;
    logic [VALUE_WIDTH-1:0] r_scan_min;
    logic [IDX_W-1:0]       r_scan_idx;
    logic                   r_scan_any;
    logic                   r_drain_done;

    logic                   w_hit, w_free, w_upd, w_ins, w_rep, w_drop;
    logic [IDX_W-1:0]       w_hit_idx, w_free_idx;
    logic                   w_more, w_cur_vld, w_out_vld, w_out_hs, w_drain_end;
    logic                   w_scan_take, w_scan_last, w_new_any;
    logic [VALUE_WIDTH-1:0] w_new_min;
    logic [IDX_W-1:0]       w_new_idx;

    // Descending loop so the lowest matching/free index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_key[i] == r_cand_key)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_vld[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_upd  = w_hit && (r_cand_val > r_val[w_hit_idx]);
    assign w_ins  = !w_hit && w_free;
    assign w_rep  = !w_hit && !w_free && (r_cand_val > r_min_value);
    assign w_drop = !w_hit && !w_free && !(r_cand_val > r_min_value);

    always_comb begin
        w_more = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (i > int'(r_idx))) w_more = 1'b1;
        end
    end

    assign w_cur_vld   = r_vld[r_idx];
    assign w_out_vld   = (r_state == S_DRAIN) && w_cur_vld;
    assign w_out_hs    = w_out_vld && kv_out_ready;
    // Ends on the final handshake, or immediately once nothing valid remains at or above r_idx.
    assign w_drain_end = (r_state == S_DRAIN) && !w_more && (!w_cur_vld || kv_out_ready);

    assign w_scan_take = r_vld[r_idx] && (!r_scan_any || (r_val[r_idx] < r_scan_min));
    assign w_scan_last = (r_idx == IDX_W'(DEPTH - 1));
    assign w_new_any   = r_scan_any || w_scan_take;
    assign w_new_min   = w_scan_take ? r_val[r_idx] : r_scan_min;
    assign w_new_idx   = w_scan_take ? r_idx : r_scan_idx;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (drain_req)        w_state_nxt = S_DRAIN;
                else if (kv_in_valid) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: w_state_nxt = (w_upd || w_ins || w_rep) ? S_SCAN : S_IDLE;
            S_SCAN:   if (w_scan_last) w_state_nxt = S_IDLE;
            S_DRAIN:  if (w_drain_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_key[i] <= '0;
                r_val[i] <= '0;
            end
            r_vld        <= '0;
            r_cand_key   <= '0;
            r_cand_val   <= '0;
            r_idx        <= '0;
            r_occ        <= '0;
            r_min_value  <= '0;
            r_min_idx    <= '0;
            r_dropped    <= '0;
            r_scan_min   <= '0;
            r_scan_idx   <= '0;
            r_scan_any   <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= w_drain_end;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (!drain_req && kv_in_valid) begin
                        r_cand_key <= kv_in_key;
                        r_cand_val <= kv_in_value;
                    end
                end
                S_LOOKUP: begin
                    r_idx      <= '0;
                    r_scan_any <= 1'b0;
                    r_scan_min <= '0;
                    r_scan_idx <= '0;
                    if (w_upd) begin
                        r_val[w_hit_idx] <= r_cand_val;
                    end else if (w_ins) begin
                        r_vld[w_free_idx] <= 1'b1;
                        r_key[w_free_idx] <= r_cand_key;
                        r_val[w_free_idx] <= r_cand_val;
                        r_occ             <= r_occ + (IDX_W+1)'(1);
                    end else if (w_rep) begin
                        r_key[r_min_idx] <= r_cand_key;
                        r_val[r_min_idx] <= r_cand_val;
                    end else if (w_drop && (r_dropped != '1)) begin
                        r_dropped <= r_dropped + 32'd1;
                    end
                end
                S_SCAN: begin
                    r_scan_any <= w_new_any;
                    r_scan_min <= w_new_min;
                    r_scan_idx <= w_new_idx;
                    r_idx      <= r_idx + IDX_W'(1);
                    if (w_scan_last) begin
                        r_min_value <= w_new_any ? w_new_min : '0;
                        r_min_idx   <= w_new_any ? w_new_idx : '0;
                    end
                end
                S_DRAIN: begin
                    if (!w_drain_end && (!w_cur_vld || kv_out_ready)) r_idx <= r_idx + IDX_W'(1);
`ifdef CMS_TOPK_CLEAR_ON_DRAIN_EN
                    if (w_out_hs) begin
                        r_vld[r_idx] <= 1'b0;
                        r_occ        <= r_occ - (IDX_W+1)'(1);
                    end
                    if (w_drain_end) begin
                        r_min_value <= '0;
                        r_min_idx   <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign kv_in_ready   = ap_rst_n && (r_state == S_IDLE) && !drain_req;
    assign kv_out_valid  = w_out_vld;
    assign kv_out_key    = w_out_vld ? r_key[r_idx] : '0;
    assign kv_out_value  = w_out_vld ? r_val[r_idx] : '0;
    assign kv_out_last   = w_out_vld && !w_more;
    assign drain_done    = r_drain_done;
    assign occupancy     = r_occ;
    assign min_value     = r_min_value;
    assign dropped_count = r_dropped;

endmodule

// File: tb/tb_cms_topk_table.sv
// Bench for cms_topk_table (DEPTH=4): directed scenarios plus random inserts/drains,
// drained beats checked by a scoreboard monitor against a queue filled from a reference model.
module tb_cms_topk_table;
    localparam int DEPTH = 4;

    logic        ap_clk, ap_rst_n;
    logic [31:0] kv_in_key, kv_in_value;
    logic        kv_in_valid, kv_in_ready, drain_req;
    logic [31:0] kv_out_key, kv_out_value;
    logic        kv_out_valid, kv_out_ready, kv_out_last, drain_done;
    logic [2:0]  occupancy;
    logic [31:0] min_value, dropped_count;

    cms_topk_table #(.DEPTH(DEPTH), .KEY_WIDTH(32), .VALUE_WIDTH(32)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .kv_in_key(kv_in_key), .kv_in_value(kv_in_value),
        .kv_in_valid(kv_in_valid), .kv_in_ready(kv_in_ready),
        .drain_req(drain_req),
        .kv_out_key(kv_out_key), .kv_out_value(kv_out_value),
        .kv_out_valid(kv_out_valid), .kv_out_ready(kv_out_ready),
        .kv_out_last(kv_out_last), .drain_done(drain_done),
        .occupancy(occupancy), .min_value(min_value), .dropped_count(dropped_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [31:0] key;
        logic [31:0] val;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;

    logic [31:0] mkey [DEPTH];
    logic [31:0] mval [DEPTH];
    bit          mvld [DEPTH];
    logic [31:0] mdrop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mvld[i] = 1'b0;
    endtask

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mvld[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_min();
        logic [31:0] m = 32'hFFFF_FFFF;
        bit any = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (mvld[i] && mval[i] <= m) begin m = mval[i]; any = 1'b1; end
        return any ? m : 32'd0;
    endfunction

    // Top-K rules: hit keeps the max; miss fills a free slot, else evicts the smallest if beaten.
    task automatic model_insert(input logic [31:0] k, input logic [31:0] v, output bit changed);
        int mi;
        changed = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (mvld[i] && mkey[i] == k) begin
                if (v > mval[i]) begin mval[i] = v; changed = 1'b1; end
                return;
            end
        for (int i = 0; i < DEPTH; i++)
            if (!mvld[i]) begin
                mvld[i] = 1'b1; mkey[i] = k; mval[i] = v; changed = 1'b1;
                return;
            end
        mi = 0;
        for (int i = 1; i < DEPTH; i++) if (mval[i] < mval[mi]) mi = i;
        if (v > mval[mi]) begin
            mkey[mi] = k; mval[mi] = v; changed = 1'b1;
        end else if (mdrop != 32'hFFFF_FFFF) begin
            mdrop = mdrop + 1;
        end
    endtask

    // Scoreboard monitor: pops expected beats on every handshake and checks stall stability.
    logic        pv, pr;
    logic [31:0] pk, pvl;
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid", kv_out_valid, 1);
                check("stall_key", kv_out_key, pk);
                check("stall_value", kv_out_value, pvl);
            end
            if (kv_out_valid && kv_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got key 0x%0h value 0x%0h with no beat expected", kv_out_key, kv_out_value);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_key", kv_out_key, e.key);
                    check("beat_value", kv_out_value, e.val);
                    check("beat_last", kv_out_last, e.last);
                end
            end
            if (drain_done) done_seen++;
            pv = kv_out_valid; pr = kv_out_ready; pk = kv_out_key; pvl = kv_out_value;
        end
    end

    task automatic check_status();
        check("occupancy", occupancy, model_occ());
        check("min_value", min_value, model_min());
        check("dropped_count", dropped_count, mdrop);
    endtask

    // Called at posedge+1 right after the accept edge.
    task automatic finish_insert(input logic [31:0] k, input logic [31:0] v);
        int lat;
        bit ch;
        lat = 1;
        while (lat < 50) begin
            @(negedge ap_clk);
            if (kv_in_ready) break;
            lat++;
        end
        model_insert(k, v, ch);
        check("insert_latency", lat, ch ? DEPTH + 2 : 2);
        check_status();
    endtask

    task automatic wait_accept(input logic [31:0] k, input logic [31:0] v);
        int n;
        @(posedge ap_clk); #1;
        kv_in_key = k; kv_in_value = v; kv_in_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge ap_clk);
            if (kv_in_ready) break;
        end
        check("accept_in_time", n < 50, 1);
        @(posedge ap_clk); #1;
        kv_in_valid = 1'b0;
    endtask

    task automatic do_insert(input logic [31:0] k, input logic [31:0] v);
        wait_accept(k, v);
        finish_insert(k, v);
    endtask

    // mode 0: ready alternates 1,0,1..; 1: always ready; 2: random ready.
    task automatic do_drain(input int mode, input bit with_cand, input logic [31:0] ck, input logic [31:0] cv);
        int last_i, cyc, leak, d0, nbeats;
        beat_t b;
        last_i = -1;
        for (int i = 0; i < DEPTH; i++) if (mvld[i]) last_i = i;
        nbeats = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mvld[i]) begin
                b.key = mkey[i]; b.val = mval[i]; b.last = (i == last_i);
                exp_q.push_back(b);
                nbeats++;
            end
        d0 = done_seen;
        @(posedge ap_clk); #1;
        drain_req = 1'b1;
        kv_out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (with_cand) begin
            kv_in_key = ck; kv_in_value = cv; kv_in_valid = 1'b1;
        end
        @(negedge ap_clk);
        check("ready_low_on_drain_req", kv_in_ready, 0);
        @(posedge ap_clk); #1;
        drain_req = 1'b0;
        cyc = 0;
        leak = 0;
        while (cyc < 200) begin
            @(negedge ap_clk);
            if (drain_done) break;
            if (kv_in_ready) leak++;
            @(posedge ap_clk); #1;
            case (mode)
                0:       kv_out_ready = !kv_out_ready;
                1:       kv_out_ready = 1'b1;
                default: kv_out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
        check("drain_finished", cyc < 200, 1);
        check("ready_low_during_drain", leak, 0);
        if (with_cand) check("cand_ready_after_done", kv_in_ready, 1);
        #1;
        kv_out_ready = 1'b0;
        check("drain_done_pulses", done_seen - d0, 1);
        check("beats_left", exp_q.size(), 0);
        if (nbeats == 0) check("empty_drain_cycles", cyc, 1);
        exp_q.delete();
`ifdef CMS_TOPK_CLEAR_ON_DRAIN_EN
        model_clear();
`endif
        check("occ_after_drain", occupancy, model_occ());
        check("min_after_drain", min_value, model_min());
        if (with_cand) begin
            @(posedge ap_clk); #1;
            kv_in_valid = 1'b0;
            finish_insert(ck, cv);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ap_rst_n = 1'b0; kv_in_key = '0; kv_in_value = '0; kv_in_valid = 1'b0;
        drain_req = 1'b0; kv_out_ready = 1'b0;
        model_clear();
        mdrop = '0;
        #3;
        check("rst_ready", kv_in_ready, 0);
        check("rst_out_valid", kv_out_valid, 0);
        check("rst_drain_done", drain_done, 0);
        check_status();
        #19 ap_rst_n = 1'b1;

        do_drain(1, 1'b0, 0, 0);

        do_insert(32'h1001, 10);
        do_insert(32'h1002, 20);
        do_insert(32'h1003, 30);
        do_insert(32'h1004, 40);
        do_insert(32'h1005, 5);
        do_insert(32'h1006, 50);
        do_insert(32'h1002, 15);
        do_insert(32'h1002, 60);
        do_drain(0, 1'b0, 0, 0);
        do_drain(1, 1'b0, 0, 0);

        // Reset asserted two cycles into the min rescan.
        wait_accept(32'h1008, 70);
        @(posedge ap_clk);
        @(posedge ap_clk); #3;
        ap_rst_n = 1'b0;
        #1;
        model_clear();
        mdrop = '0;
        check("midscan_rst_ready", kv_in_ready, 0);
        check("midscan_rst_out_valid", kv_out_valid, 0);
        check("midscan_rst_out_last", kv_out_last, 0);
        check("midscan_rst_drain_done", drain_done, 0);
        check_status();
        @(posedge ap_clk);
        @(negedge ap_clk); #2;
        ap_rst_n = 1'b1;
        do_insert(32'h1007, 1);

        do_drain(1, 1'b1, 32'h1009, 9);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 8)
                do_insert(32'h100 + 32'($urandom_range(0, 7)), 32'($urandom_range(0, 60)));
            else
                do_drain(int'($urandom_range(0, 2)), 1'b0, 0, 0);
        end
        do_drain(2, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
